// File: rtl/ram_sync_shared_bus_if.sv
// Shared-bus connection between a bus master and ram_sync_shared_bus.
// Data is a resolved wire: the RAM drives it in DRIVE and the master drives it for writes.
interface ram_sync_shared_bus_if #(
    parameter int size     = 4,
    parameter int wordSize = 8
);
    logic [size-1:0]     address;
    wire  [wordSize-1:0] Data;
    logic                cs;
    logic                read;
    logic                busy;
    logic                valid;

    modport slave (
        input  address,
        input  cs,
        input  read,
        output busy,
        output valid,
        inout  Data
    );

    modport master (
        output address,
        output cs,
        output read,
        input  busy,
        input  valid,
        inout  Data
    );
endinterface

// File: rtl/ram_sync_shared_bus.sv
// Synchronous single-port RAM on a shared tri-state data bus with programmable read
// latency, read-valid strobe, busy flag and an optional zeroing sweep after reset.
module ram_sync_shared_bus #(
    parameter int size         = 4,
    parameter int wordSize     = 8,
    parameter int readLatency  = 1,
    parameter int clearOnReset = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_sync_shared_bus_if.slave  bus
);

    typedef enum logic [1:0] {CLEAR, IDLE, READ_WAIT, DRIVE} state_e;

    // READ_WAIT counts down to zero before DRIVE, so it is loaded with latency-2.
    localparam logic [1:0] WAIT_INIT = (readLatency > 1) ? 2'(readLatency - 2) : 2'd0;

    state_e              state_q;
    logic [size-1:0]     clr_ptr_q;
    logic [1:0]          wait_cnt_q;
    logic [wordSize-1:0] rdata_q;
    logic                busy_q;
    logic                valid_q;
    logic [wordSize-1:0] mem_q [1<<size];

    logic                mem_we;
    logic [size-1:0]     mem_waddr;
    logic [wordSize-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.address;
        mem_wdata = bus.Data;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
            end else if (state_q == IDLE && bus.cs && !bus.read) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            wait_cnt_q <= '0;
            clr_ptr_q  <= '0;
            rdata_q    <= '0;
            if (clearOnReset != 0) begin
                state_q <= CLEAR;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == '1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.cs && bus.read) begin
                        rdata_q <= mem_q[bus.address];
                        busy_q  <= 1'b1;
                        if (readLatency == 1) begin
                            state_q <= DRIVE;
                            valid_q <= 1'b1;
                        end else begin
                            state_q    <= READ_WAIT;
                            wait_cnt_q <= WAIT_INIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= DRIVE;
                        valid_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                DRIVE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.Data  = valid_q ? rdata_q : 'z;

endmodule

// File: tb/tb_ram_sync_shared_bus.sv
// Directed bench: four RAM instances (latency 2/clear, latency 2/retain, latency 1/clear,
// latency 4/retain) on separate buses sharing one clock and address/read stimulus.
module tb_ram_sync_shared_bus;
    localparam int SZ = 2;
    localparam int W  = 4;
    localparam logic [W-1:0] PARK = 4'b0101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    rst_v;
    logic [3:0]    cs_v;
    logic [3:0]    den;
    logic          rd;
    logic [SZ-1:0] addr;
    logic [W-1:0]  dv;
    logic [3:0]    busy_w;
    logic [3:0]    valid_w;
    logic [W-1:0]  dat [4];

    int n_run  = 0;
    int n_fail = 0;

    ram_sync_shared_bus_if #(.size(SZ), .wordSize(W)) bif [4] ();

    for (genvar gk = 0; gk < 4; gk++) begin : g_bus
        assign bif[gk].address = addr;
        assign bif[gk].cs      = cs_v[gk];
        assign bif[gk].read    = rd;
        assign bif[gk].Data    = den[gk] ? dv : 'z;
        assign busy_w[gk]      = bif[gk].busy;
        assign valid_w[gk]     = bif[gk].valid;
        assign dat[gk]         = bif[gk].Data;
    end

    ram_sync_shared_bus #(.size(SZ), .wordSize(W), .readLatency(2), .clearOnReset(1))
        u_l2_clr (.clk(clk), .rst(rst_v[0]), .bus(bif[0]));
    ram_sync_shared_bus #(.size(SZ), .wordSize(W), .readLatency(2), .clearOnReset(0))
        u_l2_ret (.clk(clk), .rst(rst_v[1]), .bus(bif[1]));
    ram_sync_shared_bus #(.size(SZ), .wordSize(W), .readLatency(1), .clearOnReset(1))
        u_l1_clr (.clk(clk), .rst(rst_v[2]), .bus(bif[2]));
    ram_sync_shared_bus #(.size(SZ), .wordSize(W), .readLatency(4), .clearOnReset(0))
        u_l4_ret (.clk(clk), .rst(rst_v[3]), .bus(bif[3]));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A released bus lets the bench's park pattern through unchanged.
    task automatic check_released(input int k, input string tag);
        dv     = PARK;
        den[k] = 1'b1;
        #1;
        check({tag, " released"}, dat[k], PARK);
        den[k] = 1'b0;
        #1;
    endtask

    task automatic wr(input int k, input logic [SZ-1:0] a, input logic [W-1:0] d);
        addr    = a;
        rd      = 1'b0;
        dv      = d;
        cs_v[k] = 1'b1;
        den[k]  = 1'b1;
        tick();
        cs_v[k] = 1'b0;
        den[k]  = 1'b0;
        #1;
        check("wr busy", busy_w[k], 1'b0);
    endtask

    // Read accepted at edge N: valid only in the cycle after edge N+lat-1, busy until edge N+lat.
    task automatic rd_chk(input int k, input int lat, input logic [SZ-1:0] a,
                          input logic [W-1:0] exp, input string tag);
        addr    = a;
        rd      = 1'b1;
        cs_v[k] = 1'b1;
        tick();
        cs_v[k] = 1'b0;
        rd      = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) tick();
            check({tag, " valid"}, valid_w[k], (c == lat - 1));
            check({tag, " busy"}, busy_w[k], (c < lat));
            if (c == lat - 1) check({tag, " data"}, dat[k], exp);
            else check_released(k, tag);
        end
    endtask

    initial begin
        rst_v = '1;
        cs_v  = '0;
        den   = '0;
        rd    = 1'b0;
        addr  = '0;
        dv    = '0;
        tick();
        rst_v = '0;

        // Clear sweep on the latency-2 clearing instance
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        check("rst busy", busy_w[0], 1'b1);
        check("rst valid", valid_w[0], 1'b0);
        check_released(0, "rst bus");
        for (int i = 1; i < 4; i++) begin
            tick();
            check("sweep busy", busy_w[0], 1'b1);
        end
        tick();
        check("sweep done", busy_w[0], 1'b0);
        for (int a = 0; a < 4; a++) rd_chk(0, 2, SZ'(a), 4'b0000, "cleared");

        wr(0, 2'b00, 4'b1000);
        wr(0, 2'b01, 4'b0000);
        rd_chk(0, 2, 2'b00, 4'b1000, "rd00");
        rd_chk(0, 2, 2'b01, 4'b0000, "rd01");

        wr(0, 2'b10, 4'b0011);
        wr(0, 2'b10, 4'b0101);
        wr(0, 2'b10, 4'b1111);
        rd_chk(0, 2, 2'b10, 4'b1111, "b2b");

        // Write attempt during READ_WAIT must be dropped
        addr    = 2'b11;
        rd      = 1'b1;
        cs_v[0] = 1'b1;
        tick();
        check("drop busy", busy_w[0], 1'b1);
        rd      = 1'b0;
        dv      = 4'b0110;
        den[0]  = 1'b1;
        tick();
        cs_v[0] = 1'b0;
        den[0]  = 1'b0;
        #1;
        check("drop valid", valid_w[0], 1'b1);
        check("drop data", dat[0], 4'b0000);
        tick();
        check("drop idle", busy_w[0], 1'b0);
        rd_chk(0, 2, 2'b11, 4'b0000, "drop rd11");

        // Reset mid-read with clearing
        wr(0, 2'b00, 4'b1000);
        addr    = 2'b00;
        rd      = 1'b1;
        cs_v[0] = 1'b1;
        tick();
        cs_v[0]  = 1'b0;
        rd       = 1'b0;
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        check("abort valid", valid_w[0], 1'b0);
        check("abort busy", busy_w[0], 1'b1);
        check_released(0, "abort bus");
        for (int i = 1; i < 4; i++) begin
            tick();
            check("abort late valid", valid_w[0], 1'b0);
            check("abort sweep busy", busy_w[0], 1'b1);
        end
        tick();
        check("abort sweep done", busy_w[0], 1'b0);
        rd_chk(0, 2, 2'b00, 4'b0000, "abort rd00");

        // Reset mid-read with contents retained
        rst_v[1] = 1'b1;
        tick();
        rst_v[1] = 1'b0;
        check("ret rst busy", busy_w[1], 1'b0);
        wr(1, 2'b00, 4'b1000);
        addr    = 2'b00;
        rd      = 1'b1;
        cs_v[1] = 1'b1;
        tick();
        cs_v[1]  = 1'b0;
        rd       = 1'b0;
        rst_v[1] = 1'b1;
        tick();
        rst_v[1] = 1'b0;
        check("ret abort valid", valid_w[1], 1'b0);
        check("ret abort busy", busy_w[1], 1'b0);
        check_released(1, "ret abort bus");
        tick();
        check("ret late valid", valid_w[1], 1'b0);
        rd_chk(1, 2, 2'b00, 4'b1000, "ret rd00");

        // Latency 1: back-to-back reads at minimum spacing
        rst_v[2] = 1'b1;
        tick();
        rst_v[2] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("l1 sweep done", busy_w[2], 1'b0);
        wr(2, 2'b01, 4'b1010);
        rd_chk(2, 1, 2'b01, 4'b1010, "l1 rd01a");
        rd_chk(2, 1, 2'b01, 4'b1010, "l1 rd01b");
        rd_chk(2, 1, 2'b11, 4'b0000, "l1 rd11");

        // Latency 4: back-to-back reads at minimum spacing
        rst_v[3] = 1'b1;
        tick();
        rst_v[3] = 1'b0;
        check("l4 rst busy", busy_w[3], 1'b0);
        wr(3, 2'b10, 4'b0101);
        wr(3, 2'b11, 4'b1100);
        rd_chk(3, 4, 2'b10, 4'b0101, "l4 rd10");
        rd_chk(3, 4, 2'b11, 4'b1100, "l4 rd11");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
